line_delay_ctrl: RTL

- Streaming line-delay controller. It turns one efx_simple_dual_port_ram instance (one-clock mode, READ_FIRST) into a programmable-length shift register for the stitching pixel pipeline.
- It drives the RAM's write and read ports and accepts a pixel stream.
- Each accepted pixel is returned exactly cfg_len accepted pixels later, and is then qualified by out_valid.

---
 rtl/line_delay_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/line_delay_ctrl.sv
// line_delay_ctrl
//   Streaming line-delay controller for the stitching pixel pipeline. It uses one
//   external simple dual-port RAM (one-clock mode, READ_FIRST) as a circular
//   buffer. Each accepted pixel comes back exactly L accepted pixels later, where
//   L is the delay length latched from cfg_len.
//
//   Ports
//     clk, reset      single clock, synchronous active-high reset
//     cfg_len         requested delay length, sampled only while idle
//     flush           synchronous restart to idle (RAM contents kept)
//     in_valid/data   pixel stream input, always accepted
//     out_valid/data  delayed pixel; out_data comes straight from ram_rdata
//     filled          delay line fully primed
//     ram_*           write and read ports of the RAM
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | empty line, L follows cfg_len, first accept starts priming
//   FILL  | priming, fewer than L samples written since restart
//   RUN   | primed, every accept reads the sample pushed L accepts ago
module line_delay_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  filled,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int RD_LAT = 1 + OUTPUT_REG;
  localparam logic [ADDR_WIDTH:0] LEN_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   fill_cnt_q, fill_cnt_d;
  logic                  filled_q, filled_d;
  logic [RD_LAT-1:0]     vpipe_q, vpipe_d;

  logic                  accept;
  logic                  rd_tag;
  logic                  ptr_last;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [ADDR_WIDTH:0]   fill_inc;

  // The same cycle that accepts a pixel writes it and reads the oldest one
  // at the same address; READ_FIRST hands back the old content.
  assign accept    = in_valid & ~reset & ~flush;
  assign ram_we    = accept;
  assign ram_re    = accept;
  assign ram_waddr = ptr_q;
  assign ram_raddr = ptr_q;
  assign ram_wdata = in_data;

  assign out_data  = ram_rdata;
  assign out_valid = vpipe_q[RD_LAT-1];
  assign filled    = filled_q;

  assign ptr_last = ({1'b0, ptr_q} == (len_q - LEN_ONE));
  assign ptr_next = ptr_last ? '0 : ptr_q + ADDR_WIDTH'(1);
  assign fill_inc = fill_cnt_q + LEN_ONE;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ptr_d      = ptr_q;
    fill_cnt_d = fill_cnt_q;
    filled_d   = filled_q;
    rd_tag     = 1'b0;

    // Out-of-range or zero lengths fall back to the full buffer.
    if (state_q == IDLE) begin
      if ((cfg_len == LEN_ZERO) || (cfg_len > LEN_MAX)) begin
        len_d = LEN_MAX;
      end else begin
        len_d = cfg_len;
      end
    end

    if (flush) begin
      state_d    = IDLE;
      ptr_d      = '0;
      fill_cnt_d = '0;
      filled_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ptr_d      = ptr_next;
            fill_cnt_d = LEN_ONE;
            if (len_q == LEN_ONE) begin
              state_d  = RUN;
              filled_d = 1'b1;
            end else begin
              state_d  = FILL;
            end
          end
        end
        FILL: begin
          if (accept) begin
            ptr_d      = ptr_next;
            fill_cnt_d = fill_inc;
            if (fill_inc == len_q) begin
              state_d  = RUN;
              filled_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            ptr_d  = ptr_next;
            rd_tag = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Read-valid tag follows the RAM read latency.
    vpipe_d[0] = rd_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
    if (flush) begin
      vpipe_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= LEN_MAX;
      ptr_q      <= '0;
      fill_cnt_q <= '0;
      filled_q   <= 1'b0;
      vpipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
      fill_cnt_q <= fill_cnt_d;
      filled_q   <= filled_d;
      vpipe_q    <= vpipe_d;
    end
  end

endmodule
